// File: rtl/comm_cmd_sequencer_if.sv
// Handshake and RAM bundle between the host byte link, the sequencer and the core.
// master is the sequencer side, slave is the UART/RAM/core side.
interface comm_cmd_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              cpu_start;
    logic              cpu_running;
    logic              busy;

    modport master (
        input  rx_valid, rx_data, tx_ready, mem_rdata, cpu_running,
        output tx_valid, tx_data, mem_addr, mem_wdata, mem_we,
        output cpu_start, busy
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, mem_rdata, cpu_running,
        input  tx_valid, tx_data, mem_addr, mem_wdata, mem_we,
        input  cpu_start, busy
    );
endinterface

// File: rtl/comm_cmd_sequencer.sv
// Host command sequencer: decodes p/r/w/x/s bytes, streams the program
// image to/from RAM, starts the core and answers with status bytes.
module comm_cmd_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    comm_cmd_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE, RESP, WR_HI, WR_LO, RD_ADDR, RD_HI, RD_LO
    } state_t;

    localparam logic [7:0] C_P = 8'h70;
    localparam logic [7:0] C_S = 8'h73;
    localparam logic [7:0] C_X = 8'h78;
    localparam logic [7:0] C_W = 8'h77;
    localparam logic [7:0] C_R = 8'h72;
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cpu_start_q, cpu_start_d;
    logic              rd_wait_q, rd_wait_d;
    logic [7:0]        rd_lo_q, rd_lo_d;
    logic              go_resp;
    logic [7:0]        resp_b;
    logic              last;

    assign last = (addr_q == LAST);

    always_comb begin
        state_d     = state_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        mem_we_d    = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_start_d = 1'b0;
        rd_wait_d   = rd_wait_q;
        rd_lo_d     = rd_lo_q;
        go_resp     = 1'b0;
        resp_b      = 8'h3F;

        // Address advances the cycle after the write strobe so the
        // strobe cycle still shows the word's own address.
        if (mem_we_q && !last) begin
            addr_d = addr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    unique case (1'b1)
                        bus.rx_data == C_P: begin
                            go_resp = 1'b1;
                            resp_b  = 8'h50;
                        end
                        bus.rx_data == C_S: begin
                            go_resp = 1'b1;
                            resp_b  = bus.cpu_running ? 8'h2B : 8'h2D;
                        end
                        bus.rx_data == C_X: begin
                            go_resp     = 1'b1;
                            resp_b      = bus.cpu_running ? 8'h21 : 8'h58;
                            cpu_start_d = !bus.cpu_running;
                        end
                        bus.rx_data == C_W: begin
                            if (bus.cpu_running) begin
                                go_resp = 1'b1;
                                resp_b  = 8'h21;
                            end else begin
                                addr_d  = '0;
                                state_d = WR_HI;
                            end
                        end
                        bus.rx_data == C_R: begin
                            if (bus.cpu_running) begin
                                go_resp = 1'b1;
                                resp_b  = 8'h21;
                            end else begin
                                addr_d    = '0;
                                rd_wait_d = 1'b0;
                                state_d   = RD_ADDR;
                            end
                        end
                        default: begin
                            go_resp = 1'b1;
                            resp_b  = 8'h3F;
                        end
                    endcase
                end
            end
            RESP: begin
                // First RESP cycle only loads the byte; valid rises next.
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                end else if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            WR_HI: begin
                if (bus.rx_valid) begin
                    wdata_d[DATA_W-1:8] = bus.rx_data;
                    state_d             = WR_LO;
                end
            end
            WR_LO: begin
                if (bus.rx_valid) begin
                    wdata_d[7:0] = bus.rx_data;
                    mem_we_d     = 1'b1;
                    if (last) begin
                        go_resp = 1'b1;
                        resp_b  = 8'h4B;
                    end else begin
                        state_d = WR_HI;
                    end
                end
            end
            RD_ADDR: begin
                if (!rd_wait_q) begin
                    rd_wait_d = 1'b1;
                end else begin
                    rd_wait_d  = 1'b0;
                    tx_data_d  = bus.mem_rdata[DATA_W-1:8];
                    rd_lo_d    = bus.mem_rdata[7:0];
                    tx_valid_d = 1'b1;
                    state_d    = RD_HI;
                end
            end
            RD_HI: begin
                if (bus.tx_ready) begin
                    tx_data_d = rd_lo_q;
                    state_d   = RD_LO;
                end
            end
            RD_LO: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        addr_d    = addr_q + 1'b1;
                        rd_wait_d = 1'b0;
                        state_d   = RD_ADDR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_resp) begin
            state_d    = RESP;
            tx_data_d  = resp_b;
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            mem_we_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_start_q <= 1'b0;
            rd_wait_q   <= 1'b0;
            rd_lo_q     <= '0;
        end else begin
            state_q     <= state_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            mem_we_q    <= mem_we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_start_q <= cpu_start_d;
            rd_wait_q   <= rd_wait_d;
            rd_lo_q     <= rd_lo_d;
        end
    end

    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_start = cpu_start_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_comm_cmd_sequencer.sv
// Randomized bench for comm_cmd_sequencer with a command-level
// reference model, a RAM model and a transmit/write scoreboard.
module tb_comm_cmd_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    comm_cmd_sequencer_if #(.ADDR_W(8), .DATA_W(16)) bus();

    comm_cmd_sequencer #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RAM model: synchronous read, one-cycle latency
    logic [15:0] ram [256];
    logic [15:0] rdata_q;
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        rdata_q <= ram[bus.mem_addr];
    end
    assign bus.mem_rdata = rdata_q;

    // Transmit ready: forced level or random
    logic rdy_force = 1'b1;
    logic rnd_en = 1'b0;
    logic rnd_bit = 1'b1;
    always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign bus.tx_ready = rnd_en ? rnd_bit : rdy_force;

    // Scoreboard captures
    logic [7:0]  txq [$];
    logic [23:0] wrq [$];
    int starts = 0;
    int stab_viol = 0;
    logic       pv = 1'b0;
    logic       pa = 1'b0;
    logic [7:0] pd = 8'h00;

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
            if (bus.mem_we) wrq.push_back({bus.mem_addr, bus.mem_wdata});
            if (bus.cpu_start) starts++;
            if (pv && !pa && (!bus.tx_valid || bus.tx_data != pd))
                stab_viol++;
            pv = bus.tx_valid;
            pa = bus.tx_valid && bus.tx_ready;
            pd = bus.tx_data;
        end else begin
            pv = 1'b0;
        end
    end

    // Reference model
    logic [15:0] ref_mem [256];

    function automatic logic [7:0] exp_resp(input logic [7:0] c,
                                            input logic run);
        case (c)
            8'h70:   return 8'h50;
            8'h73:   return run ? 8'h2B : 8'h2D;
            8'h78:   return run ? 8'h21 : 8'h58;
            8'h77:   return 8'h21;
            8'h72:   return 8'h21;
            default: return 8'h3F;
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int c = 0;
        while (txq.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (txq.size() < n) chk({tag, "_timeout"}, txq.size(), n);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx_valid"},  bus.tx_valid, 0);
        chk({tag, "_tx_data"},   bus.tx_data, 0);
        chk({tag, "_mem_we"},    bus.mem_we, 0);
        chk({tag, "_mem_addr"},  bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_cpu_start"}, bus.cpu_start, 0);
        chk({tag, "_busy"},      bus.busy, 0);
    endtask

    initial begin
        int bad;
        int s0;
        int c;
        logic [7:0] cmd;
        logic run;

        bus.rx_valid    = 1'b0;
        bus.rx_data     = 8'h00;
        bus.cpu_running = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 'p' with ready held low: latency and hold stability
        rdy_force = 1'b0;
        send_byte(8'h70);
        chk("p_lat1_valid", bus.tx_valid, 0);
        chk("p_lat1_busy", bus.busy, 1);
        @(negedge clk);
        chk("p_lat2_valid", bus.tx_valid, 1);
        chk("p_lat2_data", bus.tx_data, 8'h50);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h50) bad++;
        end
        chk("p_hold", bad, 0);
        rdy_force = 1'b1;
        wait_tx(1, 20, "p");
        if (txq.size() > 0) chk("p_byte", txq.pop_front(), 8'h50);
        repeat (2) @(negedge clk);
        chk("p_busy_done", bus.busy, 0);
        chk("p_single", txq.size(), 0);

        // 'x' idle: cpu_start in cycle 1, 'X' in cycle 2
        s0 = starts;
        send_byte(8'h78);
        chk("x_start_c1", bus.cpu_start, 1);
        chk("x_valid_c1", bus.tx_valid, 0);
        @(negedge clk);
        chk("x_start_c2", bus.cpu_start, 0);
        chk("x_valid_c2", bus.tx_valid, 1);
        chk("x_data_c2", bus.tx_data, 8'h58);
        wait_tx(1, 20, "x");
        if (txq.size() > 0) chk("x_byte", txq.pop_front(), 8'h58);
        chk("x_one_start", starts - s0, 1);

        // Random single-byte commands with random ready
        rnd_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 4))
                0: cmd = 8'h70;
                1: cmd = 8'h73;
                2: cmd = 8'h78;
                3: cmd = 8'h71;
                default: cmd = 8'($urandom_range(0, 255));
            endcase
            run = 1'($urandom_range(0, 1));
            if ((cmd == 8'h77 || cmd == 8'h72) && !run) cmd = 8'h71;
            bus.cpu_running = run;
            s0 = starts;
            wrq.delete();
            send_byte(cmd);
            wait_tx(1, 200, "rnd");
            if (txq.size() > 0)
                chk($sformatf("rnd_%0h_%0d", cmd, run), txq.pop_front(),
                    exp_resp(cmd, run));
            chk("rnd_starts", starts - s0,
                (cmd == 8'h78 && !run) ? 1 : 0);
            chk("rnd_no_we", wrq.size(), 0);
            repeat (2) @(negedge clk);
        end
        bus.cpu_running = 1'b0;

        // Image write, word i = A500+i
        wrq.delete();
        send_byte(8'h77);
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 16'hA500 + 16'(i);
            send_byte(ref_mem[i][15:8]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(ref_mem[i][7:0]);
        end
        wait_tx(1, 500, "w");
        if (txq.size() > 0) chk("w_ack", txq.pop_front(), 8'h4B);
        chk("w_count", wrq.size(), 256);
        bad = 0;
        for (int i = 0; i < wrq.size() && i < 256; i++)
            if (wrq[i] !== {8'(i), ref_mem[i]}) bad++;
        chk("w_order_data", bad, 0);

        // Dump with stray 'p' bytes injected; must be ignored
        repeat (3) @(negedge clk);
        txq.delete();
        wrq.delete();
        send_byte(8'h72);
        c = 0;
        while (txq.size() < 512 && c < 20000) begin
            @(negedge clk);
            c++;
            bus.rx_valid = (c % 97 == 0);
            bus.rx_data  = 8'h70;
        end
        bus.rx_valid = 1'b0;
        if (txq.size() < 512) chk("r_timeout", txq.size(), 512);
        repeat (30) @(negedge clk);
        chk("r_count", txq.size(), 512);
        bad = 0;
        for (int i = 0; i < 256 && 2 * i + 1 < txq.size(); i++) begin
            if (txq[2*i]   !== ref_mem[i][15:8]) bad++;
            if (txq[2*i+1] !== ref_mem[i][7:0])  bad++;
        end
        chk("r_data", bad, 0);
        chk("r_busy_done", bus.busy, 0);
        chk("r_no_we", wrq.size(), 0);
        txq.delete();

        // Core running: w, r, x refused
        bus.cpu_running = 1'b1;
        s0 = starts;
        wrq.delete();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: cmd = 8'h77;
                1: cmd = 8'h72;
                default: cmd = 8'h78;
            endcase
            send_byte(cmd);
            wait_tx(1, 200, "run");
            if (txq.size() > 0)
                chk($sformatf("run_%0h", cmd), txq.pop_front(),
                    exp_resp(cmd, 1'b1));
            repeat (2) @(negedge clk);
        end
        chk("run_no_we", wrq.size(), 0);
        chk("run_no_start", starts - s0, 0);
        bus.cpu_running = 1'b0;

        // Reset in the middle of a write
        wrq.delete();
        send_byte(8'h77);
        for (int i = 0; i < 100; i++) send_byte(8'($urandom_range(0, 255)));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        chk("midrst_words", wrq.size(), 50);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        txq.delete();
        send_byte(8'h70);
        wait_tx(1, 200, "post_rst");
        if (txq.size() > 0) chk("post_rst_p", txq.pop_front(), 8'h50);

        chk("tx_stable", stab_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
